// File: rtl/delay_tap_scheduler_pkg.sv
// Shared definitions for the delay-line tap scheduler: FSM encoding,
// default widths and the legal tap-count ceiling.
package delay_tap_scheduler_pkg;

  localparam int unsigned DEF_BITSIZE = 16;
  localparam int unsigned DEF_ADDRLEN = 16;
  localparam int unsigned DEF_NTAPS   = 4;

  // NTAPS+3 cycles must fit inside a 64-bclk frame
  localparam int unsigned NTAPS_MAX   = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/delay_tap_scheduler.sv
// Per-frame sequencer for a single-port delay-line memory: one write of the
// new sample, then NTAPS reads at per-tap delays behind the write pointer.
module delay_tap_scheduler
  import delay_tap_scheduler_pkg::*;
#(
  parameter int unsigned BITSIZE = DEF_BITSIZE,
  parameter int unsigned ADDRLEN = DEF_ADDRLEN,
  parameter int unsigned NTAPS   = DEF_NTAPS
) (
  input  logic                       bclk,
  input  logic                       resetn,
  input  logic                       lrclk,
  input  logic                       enable,
  input  logic [BITSIZE-1:0]         wr_data,
  input  logic [NTAPS*ADDRLEN-1:0]   tap_delay,
  output logic [ADDRLEN-1:0]         mem_addr,
  output logic                       mem_wren,
  output logic [BITSIZE-1:0]         mem_datain,
  input  logic [BITSIZE-1:0]         mem_dataout,
  output logic [NTAPS*BITSIZE-1:0]   tap_data,
  output logic                       tap_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int unsigned IDXW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTAPS - 1);

  if (NTAPS < 1 || NTAPS > NTAPS_MAX) begin : g_bad_ntaps
    $error("delay_tap_scheduler: NTAPS out of range");
  end

  state_e                           state_q, state_d;
  logic                             lrclk_d_q;
  logic [ADDRLEN-1:0]               wr_ptr_q, wr_ptr_d;
  logic [ADDRLEN-1:0]               mem_addr_q, mem_addr_d;
  logic                             mem_wren_q, mem_wren_d;
  logic [BITSIZE-1:0]               mem_datain_q, mem_datain_d;
  logic [NTAPS-1:0][ADDRLEN-1:0]    dly_q, dly_d;
  logic [IDXW-1:0]                  rd_idx_q, rd_idx_d;
  logic                             drn_q, drn_d;
  logic                             iss_v_q, iss_v_d;
  logic [IDXW-1:0]                  iss_idx_q, iss_idx_d;
  logic                             cap_v_q;
  logic [IDXW-1:0]                  cap_idx_q;
  logic [NTAPS-1:0][BITSIZE-1:0]    shadow_q, shadow_d;
  logic [NTAPS-1:0][BITSIZE-1:0]    tap_data_q, tap_data_d;
  logic                             tap_valid_q, tap_valid_d;
  logic                             busy_q, busy_d;
  logic                             overrun_q, overrun_d;
  logic                             fs;
  logic [IDXW-1:0]                  nxt_idx;

  always_comb begin
    fs           = lrclk & ~lrclk_d_q;
    nxt_idx      = rd_idx_q + 1'b1;
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    mem_addr_d   = mem_addr_q;
    mem_wren_d   = 1'b0;
    mem_datain_d = mem_datain_q;
    dly_d        = dly_q;
    rd_idx_d     = rd_idx_q;
    drn_d        = drn_q;
    iss_v_d      = 1'b0;
    iss_idx_d    = iss_idx_q;
    tap_data_d   = tap_data_q;
    tap_valid_d  = 1'b0;
    busy_d       = busy_q;
    overrun_d    = overrun_q | (fs & (state_q != ST_IDLE));
    shadow_d     = shadow_q;
    // Read data lands two edges after its address was registered
    if (cap_v_q) begin
      shadow_d[cap_idx_q] = mem_dataout;
    end

    case (state_q)
      ST_IDLE: begin
        if (fs && enable) begin
          mem_datain_d = wr_data;
          dly_d        = tap_delay;
          mem_addr_d   = wr_ptr_q;
          mem_wren_d   = 1'b1;
          busy_d       = 1'b1;
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_addr_d = wr_ptr_q - dly_q[0];
        iss_v_d    = 1'b1;
        iss_idx_d  = '0;
        rd_idx_d   = '0;
        state_d    = ST_READ;
      end
      ST_READ: begin
        if (rd_idx_q != LAST_IDX) begin
          mem_addr_d = wr_ptr_q - dly_q[nxt_idx];
          iss_v_d    = 1'b1;
          iss_idx_d  = nxt_idx;
          rd_idx_d   = nxt_idx;
        end else begin
          drn_d   = 1'b0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drn_d = 1'b1;
        if (drn_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        tap_data_d  = shadow_q;
        tap_valid_d = 1'b1;
        wr_ptr_d    = wr_ptr_q + 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // lrclk_d resets high so a frame clock already high at release is no edge
  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      lrclk_d_q    <= 1'b1;
      wr_ptr_q     <= '0;
      mem_addr_q   <= '0;
      mem_wren_q   <= 1'b0;
      mem_datain_q <= '0;
      dly_q        <= '0;
      rd_idx_q     <= '0;
      drn_q        <= 1'b0;
      iss_v_q      <= 1'b0;
      iss_idx_q    <= '0;
      cap_v_q      <= 1'b0;
      cap_idx_q    <= '0;
      shadow_q     <= '0;
      tap_data_q   <= '0;
      tap_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lrclk_d_q    <= lrclk;
      wr_ptr_q     <= wr_ptr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wren_q   <= mem_wren_d;
      mem_datain_q <= mem_datain_d;
      dly_q        <= dly_d;
      rd_idx_q     <= rd_idx_d;
      drn_q        <= drn_d;
      iss_v_q      <= iss_v_d;
      iss_idx_q    <= iss_idx_d;
      cap_v_q      <= iss_v_q;
      cap_idx_q    <= iss_idx_q;
      shadow_q     <= shadow_d;
      tap_data_q   <= tap_data_d;
      tap_valid_q  <= tap_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wren   = mem_wren_q;
  assign mem_datain = mem_datain_q;
  assign tap_data   = tap_data_q;
  assign tap_valid  = tap_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/delay_tap_scheduler.md
Name: delay_tap_scheduler

Overview:
Controller that sequences a single-port delay-line memory (16-bit address, registered read data) once per audio frame in the bclk domain. On each lrclk rising edge it performs one write of the new mixed sample, then NTAPS back-to-back reads at per-tap delays behind the write pointer. All tap outputs update together with a one-cycle valid strobe. It sits between the I2S frame logic and the shared memory instance and feeds echo/multi-tap effect mixers.

Parameters:
BITSIZE, 16, sample width in bits (two's complement).
ADDRLEN, 16, memory address width; delay line holds 2^ADDRLEN samples.
NTAPS, 4, number of read taps; legal range 1..32 so that NTAPS+3 < 64 bclk per frame.

Ports:
bclk  in  1  system clock, 64 x lrclk.
resetn  in  1  asynchronous, active-low reset.
lrclk  in  1  frame clock, sampled in the bclk domain.
enable  in  1  when low, no new frame sequence starts.
wr_data  in  BITSIZE  sample to write this frame (signed).
tap_delay  in  NTAPS*ADDRLEN  packed per-tap delays in samples; tap i occupies bits [i*ADDRLEN +: ADDRLEN].
mem_addr  out  ADDRLEN  memory address (registered).
mem_wren  out  1  memory write enable (registered).
mem_datain  out  BITSIZE  memory write data (registered).
mem_dataout  in  BITSIZE  memory read data, valid 1 bclk after the address is sampled.
tap_data  out  NTAPS*BITSIZE  packed tap samples, held between updates.
tap_valid  out  1  one-cycle pulse when tap_data updates.
busy  out  1  high while a frame sequence is in progress.
overrun  out  1  sticky; set when a frame start arrives while busy.

Behaviour:
- Reset (async, resetn=0): mem_addr=0, mem_wren=0, mem_datain=0, tap_data=0, tap_valid=0, busy=0, overrun=0, wr_ptr=0, state=IDLE, lrclk_d=1. Setting lrclk_d to 1 prevents a false frame start if lrclk is high at reset release.
- Frame start: fs = lrclk & ~lrclk_d, with lrclk_d registered every bclk.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - If fs & enable, latch wr_data into mem_datain and all tap_delay values into internal registers.
  - Drive mem_addr=wr_ptr and mem_wren=1, then go to WRITE.
  - If fs & ~enable, stay in IDLE; no memory access; wr_ptr and tap_data are held.
- WRITE (1 cycle): mem_wren=0, mem_addr=wr_ptr-delay[0] (mod 2^ADDRLEN), rd_idx=0, go to READ.
- READ:
  - Each cycle, issue address wr_ptr-delay[rd_idx+1] while rd_idx < NTAPS-1.
  - After the last address is issued, go to DRAIN.
- Capture:
  - Read data for the address issued at edge k is captured into a shadow register at edge k+2, so captures lag issues by 2 cycles.
  - DRAIN covers the final 2 captures.
- DONE (1 cycle):
  - Copy shadow to tap_data, pulse tap_valid=1, wr_ptr <= wr_ptr+1 (wraps 2^ADDRLEN-1 -> 0), busy=0, go to IDLE.
- Latency: fs edge to tap_valid is NTAPS+4 bclk, which is 8 for NTAPS=4. busy is high from the IDLE->WRITE edge until the DONE edge.
- Delay boundaries:
  - Delay 0 reads the sample written in this same frame; the write completes before the read.
  - Delay 2^ADDRLEN-1 reads the oldest sample.
  - Arithmetic is unsigned modulo 2^ADDRLEN.
- tap_data and mem_datain are pass-through storage only; no arithmetic on samples.
- Changes to enable or tap_delay mid-sequence have no effect until the next fs; the sequence in progress always completes.
- fs while state != IDLE: ignored, overrun <= 1 (sticky until reset).
- Reset asserted mid-sequence aborts immediately to reset values. Partial memory writes are permitted.
- Memory contents are never cleared by this block. Unwritten locations return the memory's init contents (zero).

Decomposition:
- Shared package: FSM state encoding (IDLE/WRITE/READ/DRAIN/DONE), default BITSIZE/ADDRLEN, and the NTAPS legality limit as a constant.
- No sub-module; the memory instance lives in the parent and connects through the mem_* ports.

Test Plan:
- Reset with lrclk high, release, hold lrclk high -> no fs, busy stays 0, no mem_wren pulse.
- enable=1, NTAPS=4, delays {0,1,2,3}, write 10,20,30,40 on four frames -> after the 4th frame, tap_data = {40,30,20,10} (tap0..tap3), tap_valid 8 bclk after the fs edge.
- wr_ptr=65535, one frame with delay 1 -> mem_addr sequence 65535 (write), 65534 (read); next frame writes at 0.
- enable=0 on frame 5 -> mem_wren stays 0 for the whole frame, tap_valid not pulsed, tap_data holds, wr_ptr unchanged.
- Force a second lrclk rise 3 bclk after fs -> sequence completes normally, overrun=1 and stays 1 until resetn=0.
- Assert resetn=0 during READ -> all outputs 0 immediately; the next frame starts a clean sequence at wr_ptr=0.
